// File: rtl/window_pkg.sv
// Shared constants and tap helpers for the 5x5 packed-window bus.
package window_pkg;

  localparam int KSIZE = 5;
  localparam int NTAPS = KSIZE * KSIZE;

  function automatic int win_width(input int dwidth);
    return dwidth * NTAPS;
  endfunction

  // Tap k = r*KSIZE + c; r=0 is the oldest row, c=0 the leftmost column.
  function automatic int idx(input int r, input int c);
    return r * KSIZE + c;
  endfunction

endpackage

// File: rtl/window_gen_5x5_line_buffer.sv
// One image line of pixel storage: combinational read, synchronous write at the same address.
module line_buffer #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 720,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DWIDTH-1:0] wr_data,
  output logic [DWIDTH-1:0] rd_data
);

  logic [DWIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/window_gen_5x5.sv
// Streaming 5x5 window generator over a raster pixel stream; four chained line buffers feed a 5x5 shift window.
// Optional WINDOW_LAST_EN adds out_last, flagging the final window of each frame.
module window_gen_5x5
  import window_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DWIDTH-1:0]            in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [win_width(DWIDTH)-1:0] out_data
`ifdef WINDOW_LAST_EN
  ,
  output logic                         out_last
`endif
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int WW = win_width(DWIDTH);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          accept;
  logic          emit;
  logic          x_end;
  logic          y_end;

  logic [DWIDTH-1:0] col      [KSIZE];
  logic [DWIDTH-1:0] win      [KSIZE][KSIZE];
  logic [DWIDTH-1:0] win_next [KSIZE][KSIZE];
  logic [WW-1:0]     win_packed;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign x_end    = (x == XW'(IMG_WIDTH - 1));
  assign y_end    = (y == YW'(IMG_HEIGHT - 1));
  // Only positions whose full 5x5 neighbourhood lies in the current frame emit.
  assign emit     = accept && (x >= XW'(KSIZE - 1)) && (y >= YW'(KSIZE - 1));

  // col[i] is the oldest-to-newest column at x; each buffer shifts up from the next one.
  assign col[KSIZE-1] = in_data;

  for (genvar i = 0; i < KSIZE - 1; i++) begin : g_lb
    line_buffer #(
      .DWIDTH (DWIDTH),
      .DEPTH  (IMG_WIDTH)
    ) u_lb (
      .clock   (clock),
      .we      (accept),
      .addr    (x),
      .wr_data (col[i+1]),
      .rd_data (col[i])
    );
  end

  always_comb begin
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE - 1; c++) begin
        win_next[r][c] = win[r][c+1];
      end
      win_next[r][KSIZE-1] = col[r];
    end
  end

  always_comb begin
    win_packed = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        win_packed[idx(r, c)*DWIDTH +: DWIDTH] = win_next[r][c];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) win <= win_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      if (x_end) begin
        x <= '0;
        y <= y_end ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= win_packed;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef WINDOW_LAST_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      out_last <= 1'b0;
    end else if (emit) begin
      out_last <= x_end && y_end;
    end else if (out_ready) begin
      out_last <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_window_gen_5x5.sv
// Randomized bench for window_gen_5x5 on an 8x6 image, scoreboarded against a position-based window model.
module tb_window_gen_5x5;

  localparam int DW = 8;
  localparam int W  = 8;
  localparam int H  = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [199:0]  out_data;
`ifdef WINDOW_LAST_EN
  logic          out_last;
`endif

  window_gen_5x5 #(
    .DWIDTH     (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef WINDOW_LAST_EN
    ,
    .out_last  (out_last)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Model: raster position of the next pixel, per-frame data seed, pending windows.
  int           mx = 0;
  int           my = 0;
  int           par = 0;
  int           seed_q [2];
  logic [199:0] exp_q  [$];
  logic         last_q [$];
  int           nwin = 0;
  logic [199:0] first_win;
  logic [199:0] last_win;

  task automatic check_eq(input string tag, input logic [199:0] got, input logic [199:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int seed, input int y, input int x);
    if (seed == 0) return 8'(y * 16 + x);
    return 8'((y * 37 + x * 11 + seed) ^ (seed >> 4));
  endfunction

  function automatic logic [199:0] exp_win(input int seed, input int y, input int x);
    logic [199:0] w;
    w = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        w[(r*5+c)*8 +: 8] = pix(seed, y - 4 + r, x - 4 + c);
    return w;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    last_q.delete();
    mx = 0;
    my = 0;
    par = 0;
  endtask

  // One clock: drive at posedge+1, check at negedge, update model after the edge.
  task automatic cycle(input bit v, input bit rdy, output bit acc);
    bit pop;
    logic [199:0] cur;
    in_valid  = v;
    in_data   = v ? pix(seed_q[par], my, mx) : 8'($urandom);
    out_ready = rdy;
    @(negedge clock);
    check_eq("out_valid", out_valid, exp_q.size() != 0);
    check_eq("in_ready", in_ready, exp_q.size() == 0 || rdy);
    cur = out_data;
    if (exp_q.size() != 0) begin
      check_eq("out_data", cur, exp_q[0]);
`ifdef WINDOW_LAST_EN
      check_eq("out_last", out_last, last_q[0]);
`endif
    end
    pop = exp_q.size() != 0 && rdy;
    acc = v && (exp_q.size() == 0 || rdy);
    if (pop) begin
      if (nwin == 0) first_win = cur;
      last_win = cur;
    end
    @(posedge clock);
    #1;
    if (pop) begin
      void'(exp_q.pop_front());
      void'(last_q.pop_front());
      nwin++;
    end
    if (acc) begin
      if (mx >= 4 && my >= 4) begin
        exp_q.push_back(exp_win(seed_q[par], my, mx));
        last_q.push_back(mx == W - 1 && my == H - 1);
      end
      mx++;
      if (mx == W) begin
        mx = 0;
        my++;
        if (my == H) begin
          my = 0;
          par ^= 1;
        end
      end
    end
  endtask

  task automatic run_pixels(input int n, input int gap_pct, input int nrdy_pct, input bit bp5);
    int done   = 0;
    int budget = n * 20 + 50;
    int stall  = 0;
    bit seen   = 0;
    bit v, rdy, acc;
    while (done < n) begin
      if (budget == 0) begin
        check_eq("accept_timeout", done, n);
        return;
      end
      budget--;
      v   = ($urandom_range(99) >= gap_pct);
      rdy = ($urandom_range(99) >= nrdy_pct);
      if (bp5 && !seen && exp_q.size() != 0) begin
        seen  = 1;
        stall = 5;
      end
      if (stall > 0) begin
        rdy = 0;
        stall--;
      end
      cycle(v, rdy, acc);
      if (acc) done++;
    end
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle(0, 1, acc);
    check_eq("drain_empty", exp_q.size(), 0);
    cycle(0, 1, acc);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check_eq("valid_in_reset", out_valid, 0);
      @(posedge clock);
      #1;
    end
    model_clear();
    reset = 1'b0;
  endtask

  initial begin
    seed_q[0] = 0;
    seed_q[1] = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
`ifdef WINDOW_LAST_EN
    check_eq("rst_out_last", out_last, 0);
`endif
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();

    // Continuous frame, pattern data.
    nwin = 0;
    run_pixels(W * H, 0, 0, 0);
    drain();
    check_eq("frame_windows", nwin, 8);
    check_eq("first_k0", first_win[0 +: 8], 8'h00);
    check_eq("first_k12", first_win[96 +: 8], 8'h22);
    check_eq("first_k24", first_win[192 +: 8], 8'h44);
    check_eq("last_k0", last_win[0 +: 8], 8'h13);
    check_eq("last_k24", last_win[192 +: 8], 8'h57);

    // Five-cycle stall on the first window.
    nwin = 0;
    run_pixels(W * H, 0, 0, 1);
    drain();
    check_eq("bp_windows", nwin, 8);

    // 50% input gaps.
    nwin = 0;
    run_pixels(W * H, 50, 0, 0);
    drain();
    check_eq("gap_windows", nwin, 8);
    check_eq("gap_first_k12", first_win[96 +: 8], 8'h22);

    // Two back-to-back random-data frames with random gaps and backpressure.
    seed_q[0] = 1 + int'($urandom_range(200));
    seed_q[1] = 1 + int'($urandom_range(200));
    nwin = 0;
    run_pixels(2 * W * H, 30, 30, 0);
    drain();
    check_eq("b2b_windows", nwin, 16);

    // Reset arriving at pixel 0x31, then a fresh pattern frame.
    seed_q[0] = 0;
    seed_q[1] = 0;
    run_pixels(3 * W + 1, 0, 0, 0);
    check_eq("pre_reset_pos", my * 16 + mx, 8'h31);
    do_reset();
    nwin = 0;
    run_pixels(W * H, 20, 20, 0);
    drain();
    check_eq("post_rst_windows", nwin, 8);
    check_eq("post_rst_k12", first_win[96 +: 8], 8'h22);
    check_eq("post_rst_last_k24", last_win[192 +: 8], 8'h57);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
